// File: rtl/bus_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package bus_uart_tx_pkg;

    localparam int unsigned BUS_W    = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BAUD_W   = 16;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Register offsets selected by bus_address[2]
    localparam logic OFFSET_DATA   = 1'b0;
    localparam logic OFFSET_STATUS = 1'b1;

    localparam int unsigned STATUS_BUSY      = 0;
    localparam int unsigned STATUS_FULL      = 1;
    localparam int unsigned STATUS_EMPTY     = 2;
    localparam int unsigned STATUS_OVERFLOW  = 3;
    localparam int unsigned STATUS_COUNT_LSB = 8;

    typedef struct packed {
        logic [15:0] reserved_hi;
        logic [7:0]  count;
        logic [3:0]  reserved_lo;
        logic        overflow;
        logic        empty;
        logic        full;
        logic        busy;
    } status_reg_t;

endpackage

// File: rtl/bus_uart_tx_if.sv
// Core data-bus port of the UART transmitter register block.
interface bus_uart_tx_if;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        bus_hit;

    modport master (
        output bus_address, bus_write_data, bus_byte_enable,
               bus_read_enable, bus_write_enable,
        input  bus_read_data, bus_hit
    );

    modport slave (
        input  bus_address, bus_write_data, bus_byte_enable,
               bus_read_enable, bus_write_enable,
        output bus_read_data, bus_hit
    );
endinterface

// File: rtl/bus_uart_tx_fifo.sv
// Transmit byte FIFO with show-ahead head data; push while full is accepted only alongside a pop.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] count_next_c;

    assign do_pop_c  = pop && !empty;
    assign do_push_c = push && (!full || do_pop_c);
    assign data      = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (do_push_c && !do_pop_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    // Storage is not reset; occupancy and pointers define validity
    always_ff @(posedge clock) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
            empty <= (count_next_c == CNT_W'(0));
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA register feeds a FIFO, STATUS reports FIFO/FSM state.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic          clock,
    input  logic          reset,
    bus_uart_tx_if.slave  bus,
    output logic          uart_tx
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t              state;
    logic [BAUD_W-1:0]      baud;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [BYTE_W-1:0]      shift;
    logic                   overflow;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [BYTE_W-1:0]      fifo_data;

    logic                   hit_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   baud_last_c;
    logic                   status_clear_c;
    logic                   overflow_set_c;
    status_reg_t            status_c;
    logic                   unused_bus_bits;

    // Address decode; bits [2:0] of the base are don't-care
    assign hit_c = (bus.bus_address[31:3] == BASE_ADDRESS[31:3]) &&
                   (bus.bus_read_enable || bus.bus_write_enable);

    assign push_c = hit_c && bus.bus_write_enable &&
                    (bus.bus_address[2] == OFFSET_DATA) && bus.bus_byte_enable[0];
    assign status_clear_c = hit_c && bus.bus_write_enable &&
                            (bus.bus_address[2] == OFFSET_STATUS);

    assign baud_last_c = (baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign pop_c = !fifo_empty &&
                   ((state == IDLE) || ((state == STOP) && baud_last_c));

    assign overflow_set_c = push_c && fifo_full && !pop_c;

    assign unused_bus_bits = ^{bus.bus_write_data[31:8], bus.bus_byte_enable[3:1],
                               bus.bus_address[1:0]};

    always_comb begin
        status_c          = '0;
        status_c.count    = 8'(fifo_count);
        status_c.overflow = overflow;
        status_c.empty    = fifo_empty;
        status_c.full     = fifo_full;
        status_c.busy     = (state != IDLE);
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .push_data (bus.bus_write_data[7:0]),
        .pop       (pop_c),
        .data      (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Register interface: loads observe the pre-store state of the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.bus_read_data <= '0;
            bus.bus_hit       <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            bus.bus_hit       <= hit_c;
            bus.bus_read_data <= '0;
            if (hit_c && bus.bus_read_enable && (bus.bus_address[2] == OFFSET_STATUS)) begin
                bus.bus_read_data <= 32'(status_c);
            end
            if (overflow_set_c) begin
                overflow <= 1'b1;
            end else if (status_clear_c) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame FSM; uart_tx follows the state by one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            uart_tx <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    baud    <= '0;
                    if (!fifo_empty) begin
                        shift <= fifo_data;
                        state <= START;
                    end
                end
                START: begin
                    uart_tx <= 1'b0;
                    if (baud_last_c) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    uart_tx <= shift[0];
                    if (baud_last_c) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == BIT_IDX_W'(7)) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_last_c) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            shift <= fifo_data;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx: register-access vector table plus frame-level sequences.
module tb_bus_uart_tx;

    localparam int unsigned CPB = 4;
    localparam logic [31:0] A_DATA   = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;

    logic clk;
    logic rst;
    logic uart_tx;

    bus_uart_tx_if bus_if ();

    bus_uart_tx #(
        .BASE_ADDRESS (32'h8000_0000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clock   (clk),
        .reset   (rst),
        .bus     (bus_if.slave),
        .uart_tx (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        re;
        logic        we;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_if.bus_address      = '0;
        bus_if.bus_write_data   = '0;
        bus_if.bus_byte_enable  = '0;
        bus_if.bus_read_enable  = 1'b0;
        bus_if.bus_write_enable = 1'b0;
    endtask

    task automatic bus_drive(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, input logic re, input logic we);
        bus_if.bus_address      = a;
        bus_if.bus_write_data   = wd;
        bus_if.bus_byte_enable  = be;
        bus_if.bus_read_enable  = re;
        bus_if.bus_write_enable = we;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input logic re, input logic we);
        bus_drive(a, wd, be, re, we);
        tick();
        bus_idle();
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        access(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0);
        chk(name, bus_if.bus_read_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Bounded wait for the start bit
    task automatic wait_fall(input string name);
        int n;
        n = 0;
        while (uart_tx === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 32'(uart_tx), 32'h0);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int c);
        if (c < 4) return 1'b0;
        if (c < 36) return b[(c - 4) / 4];
        return 1'b1;
    endfunction

    initial begin
        rst = 1'b1;
        bus_idle();
        tick();
        tick();
        chk("reset_tx",    32'(uart_tx), 32'h1);
        chk("reset_hit",   32'(bus_if.bus_hit), 32'h0);
        chk("reset_rdata", bus_if.bus_read_data, 32'h0);
        rst = 1'b0;
        tick();

        // Register-access vectors, all with the transmitter idle
        vecs[0]  = '{A_STATUS,      32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0004};
        vecs[1]  = '{A_DATA,        32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vecs[2]  = '{32'h8000_0008, 32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[3]  = '{32'h8000_0008, 32'h41, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[4]  = '{A_DATA,        32'h4100, 4'b0010, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[5]  = '{32'h8000_000C, 32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6]  = '{A_STATUS,      32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0004};
        vecs[7]  = '{32'h0000_0004, 32'h0,  4'h0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[8]  = '{32'h8000_0006, 32'h0,  4'h0, 1'b1, 1'b0, 1'b1, 32'h0000_0004};
        vecs[9]  = '{A_STATUS,      32'hFF, 4'hF, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[10] = '{A_STATUS,      32'hFF, 4'hF, 1'b1, 1'b1, 1'b1, 32'h0000_0004};
        vecs[11] = '{32'h8000_0000, 32'h0,  4'h0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].re, vecs[i].we);
            chk($sformatf("vec%0d_hit", i),   32'(bus_if.bus_hit), 32'(vecs[i].exp_hit));
            chk($sformatf("vec%0d_rdata", i), bus_if.bus_read_data, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_tx", i),    32'(uart_tx), 32'h1);
        end
        repeat (5) tick();
        chk("no_push_tx_idle", 32'(uart_tx), 32'h1);

        // Single frame 0x55 with busy timing around the stop bit
        do_reset();
        access(A_DATA, 32'h55, 4'h1, 1'b0, 1'b1);
        read_status("a_status_queued", 32'h0000_0100);
        read_status("a_status_busy",   32'h0000_0005);
        wait_fall("a_start");
        for (int c = 0; c < 40; c++) begin
            chk($sformatf("a_bit%0d", c), 32'(uart_tx), 32'(exp_bit(8'h55, c)));
            if (c == 38) bus_drive(A_STATUS, 32'h0, 4'h0, 1'b1, 1'b0);
            if (c == 39) chk("a_busy_in_stop", bus_if.bus_read_data, 32'h0000_0005);
            tick();
        end
        bus_idle();
        chk("a_busy_cleared", bus_if.bus_read_data, 32'h0000_0004);
        chk("a_tx_idle", 32'(uart_tx), 32'h1);

        // Two back-to-back frames
        do_reset();
        access(A_DATA, 32'h01, 4'h1, 1'b0, 1'b1);
        access(A_DATA, 32'h02, 4'h1, 1'b0, 1'b1);
        wait_fall("b_start");
        for (int c = 0; c < 80; c++) begin
            chk($sformatf("b_bit%0d", c), 32'(uart_tx),
                32'(exp_bit((c < 40) ? 8'h01 : 8'h02, c % 40)));
            tick();
        end
        chk("b_tx_idle", 32'(uart_tx), 32'h1);
        read_status("b_status_done", 32'h0000_0004);

        // Overflow from ten stores, then clear via STATUS store
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus_drive(A_DATA, 32'(8'h10 + i), 4'h1, 1'b0, 1'b1);
            tick();
        end
        bus_idle();
        read_status("c_status_overflow", 32'h0000_080B);
        access(A_STATUS, 32'h0, 4'hF, 1'b0, 1'b1);
        chk("c_clear_hit", 32'(bus_if.bus_hit), 32'h1);
        read_status("c_status_cleared", 32'h0000_0803);

        // Reset during data bit 3 with three bytes queued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus_drive(A_DATA, 32'(8'hA0 + i), 4'h1, 1'b0, 1'b1);
            tick();
        end
        bus_idle();
        wait_fall("d_start");
        repeat (16) tick();
        chk("d_bit3_low", 32'(uart_tx), 32'h0);
        rst = 1'b1;
        #1;
        chk("d_reset_tx_high", 32'(uart_tx), 32'h1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        read_status("d_status_after", 32'h0000_0004);
        begin
            int lows;
            lows = 0;
            for (int c = 0; c < 60; c++) begin
                if (uart_tx !== 1'b1) lows++;
                tick();
            end
            chk("d_no_frames", 32'(lows), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_uart_tx.md
BUS_UART_TX -- requirements
Module: bus_uart_tx

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h8000_0000: byte address of register block; bits [2:0] ignored.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per UART bit; legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, 2..128.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bus_address  input  32  byte address from the core's data bus.
REQ-007 SHALL have port bus_write_data  input  32  store data, byte-lane aligned.
REQ-008 SHALL have port bus_byte_enable  input  4  byte-lane enables for stores.
REQ-009 SHALL have port bus_read_enable  input  1  load request.
REQ-010 SHALL have port bus_write_enable  input  1  store request.
REQ-011 SHALL have port bus_read_data  output  32  registered load data.
REQ-012 SHALL have port bus_hit  output  1  registered; high in the cycle after an accepted access, used by the top-level read-data mux.
REQ-013 SHALL have port uart_tx  output  1  serial line; idle high.

Function
REQ-014 SHALL decode a hit when bus_address[31:3] == BASE_ADDRESS[31:3]; offset = bus_address[2]: 0 = DATA, 1 = STATUS.
REQ-015 SHALL push bus_write_data[7:0] into the FIFO on a hit store to DATA with bus_byte_enable[0]=1; the store is ignored when bus_byte_enable[0]=0.
REQ-016 SHALL drop a DATA push when the FIFO is full and no pop occurs in the same cycle, and set sticky STATUS.overflow.
REQ-017 SHALL, on simultaneous push and pop while full, perform both; count unchanged; overflow unchanged.
REQ-018 SHALL clear STATUS.overflow on any hit store to STATUS; all other STATUS bits are read-only.
REQ-019 SHALL return load data one cycle after a hit with bus_read_enable: DATA -> 0; STATUS -> {16'h0, count[7:0], 4'h0, overflow, empty, full, busy} at bits [31:0]; bus_read_data = 0 when there is no hit.
REQ-020 SHALL define busy = FSM state != IDLE; count = current FIFO occupancy; full = (count == FIFO_DEPTH); empty = (count == 0).
REQ-021 SHALL implement FSM states IDLE, START, DATA, STOP with a baud counter of 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-022 SHALL, in IDLE with FIFO non-empty, pop the head byte into the shift register and enter START on the next edge.
REQ-023 SHALL drive uart_tx low for CLKS_PER_BIT cycles in START, then shift 8 data bits LSB first, each CLKS_PER_BIT cycles, in DATA.
REQ-024 SHALL drive uart_tx high for CLKS_PER_BIT cycles in STOP, then pop and enter START directly if the FIFO is non-empty, or enter IDLE otherwise; back-to-back frames have no idle cycle.
REQ-025 SHALL register uart_tx, so a frame occupies exactly 10*CLKS_PER_BIT cycles and starts one cycle after the FSM leaves IDLE.
REQ-026 SHALL ignore loads and stores with no hit.
REQ-027 SHALL treat a simultaneous bus_read_enable and bus_write_enable as a store plus a load of the pre-store state.

Reset
REQ-028 SHALL, while reset is high, immediately force: uart_tx=1, FSM=IDLE, FIFO empty, overflow=0, bus_read_data=0, bus_hit=0, counters=0.
REQ-029 SHALL abort an in-progress frame when reset is asserted mid-operation and discard the FIFO contents.

Structure
REQ-030 SHALL place the FSM state enum, the register offset constants (DATA, STATUS) and the STATUS bit positions in a shared package.
REQ-031 SHALL implement the FIFO as one sub-module, uart_tx_fifo (push, pop, data, count, full, empty), with the same clock and reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8, BASE_ADDRESS=32'h8000_0000)
REQ-032 SHALL cover: store 0x55 to 0x8000_0000 -> uart_tx low 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then high 4 cycles; busy clears after 40 cycles.
REQ-033 SHALL cover: 10 back-to-back DATA stores while idle -> first byte popped, 8 queued, 10th dropped; STATUS reads full=1, overflow=1, count=8.
REQ-034 SHALL cover: two stores 0x01, 0x02 -> stop bit of frame 1 followed immediately by start bit of frame 2; both frames complete in 80 cycles.
REQ-035 SHALL cover: idle load from 0x8000_0004 -> next cycle bus_hit=1, bus_read_data=32'h0000_0004; then a store to 0x8000_0004 after an overflow -> overflow=0.
REQ-036 SHALL cover: reset asserted during data bit 3 with 3 bytes queued -> uart_tx=1 in the same cycle; after release STATUS reads 32'h0000_0004 and no further frames are sent.
REQ-037 SHALL cover: store to 0x8000_0008, and a DATA store with bus_byte_enable=4'b0010 -> no push, bus_hit=0 for the miss, uart_tx stays high.
